// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for the register-file/ALU datapath: accepts instruction words,
// drives read/ALU/write controls, writes results back and returns them over valid/ready.
module alu_op_sequencer #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [3:0]        alu_ctrl,
    output logic [REG_AW-1:0] rd_reg1,
    output logic [REG_AW-1:0] rd_reg2,
    output logic [REG_AW-1:0] wr_reg,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              halted,
    output logic              illegal
);
    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WB, S_RESP, S_HALT} state_t;

    localparam logic [3:0] OP_ALU  = 4'h0;
    localparam logic [3:0] OP_LI   = 4'h1;
    localparam logic [3:0] OP_CMP  = 4'h2;
    localparam logic [3:0] OP_HALT = 4'hF;

    function automatic logic signed [DATA_W-1:0] sext_imm(input logic signed [15:0] v);
        return DATA_W'(v);
    endfunction

    state_t                   state_q;
    logic [3:0]               op_q;
    logic [REG_AW-1:0]        rd_q;
    logic signed [15:0]       imm_q;
    logic                     instr_ready_q, wr_en_q, res_valid_q, res_zero_q;
    logic                     halted_q, illegal_q;
    logic [3:0]               alu_ctrl_q;
    logic [REG_AW-1:0]        rd_reg1_q, rd_reg2_q, wr_reg_q;
    logic [DATA_W-1:0]        wr_data_q, res_data_q;
    logic                     in_uses_alu;

    assign in_uses_alu = (instr[31:28] == OP_ALU) || (instr[31:28] == OP_CMP);

    // Outputs are registered so each one is set on the edge that enters its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            instr_ready_q <= 1'b1;
            alu_ctrl_q    <= '0;
            rd_reg1_q     <= '0;
            rd_reg2_q     <= '0;
            wr_reg_q      <= '0;
            wr_data_q     <= '0;
            wr_en_q       <= 1'b0;
            res_data_q    <= '0;
            res_zero_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            halted_q      <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q          <= instr[31:28];
                        rd_q          <= REG_AW'(instr[27:24]);
                        imm_q         <= instr[15:0];
                        instr_ready_q <= 1'b0;
                        state_q       <= S_EXEC;
                        if (in_uses_alu) begin
                            alu_ctrl_q <= instr[3:0];
                            rd_reg1_q  <= REG_AW'(instr[23:20]);
                            rd_reg2_q  <= REG_AW'(instr[19:16]);
                        end
                    end
                end
                S_EXEC: begin
                    alu_ctrl_q <= '0;
                    rd_reg1_q  <= '0;
                    rd_reg2_q  <= '0;
                    case (op_q)
                        OP_ALU, OP_CMP: begin
                            res_data_q <= alu_result;
                            res_zero_q <= alu_zero;
                            if (op_q == OP_ALU) begin
                                wr_en_q   <= 1'b1;
                                wr_reg_q  <= rd_q;
                                wr_data_q <= alu_result;
                                state_q   <= S_WB;
                            end else begin
                                res_valid_q <= 1'b1;
                                state_q     <= S_RESP;
                            end
                        end
                        OP_LI: begin
                            res_data_q <= sext_imm(imm_q);
                            res_zero_q <= (imm_q == '0);
                            wr_en_q    <= 1'b1;
                            wr_reg_q   <= rd_q;
                            wr_data_q  <= sext_imm(imm_q);
                            state_q    <= S_WB;
                        end
                        OP_HALT: begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                        default: begin
                            illegal_q     <= 1'b1;
                            instr_ready_q <= 1'b1;
                            state_q       <= S_IDLE;
                        end
                    endcase
                end
                S_WB: begin
                    wr_en_q     <= 1'b0;
                    wr_reg_q    <= '0;
                    wr_data_q   <= '0;
                    res_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid_q   <= 1'b0;
                        instr_ready_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = instr_ready_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign rd_reg1     = rd_reg1_q;
    assign rd_reg2     = rd_reg2_q;
    assign wr_reg      = wr_reg_q;
    assign wr_data     = wr_data_q;
    assign wr_en       = wr_en_q;
    assign res_data    = res_data_q;
    assign res_zero    = res_zero_q;
    assign res_valid   = res_valid_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side driver for the register-file/ALU datapath top.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes them.
- Sequences the datapath control inputs (ALUControl, readReg1/2, writeReg, writeData, writeEnable), consumes ALUResult/Zero, and writes results back into the register file.
- Returns each completed result to the issuer over a second valid/ready handshake.

Parameters:
- DATA_W, 32, datapath width; must match the datapath top.
- REG_AW, 4, register address width (16 registers).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- instr  input  32  instruction word.
- instr_valid  input  1  instr is valid.
- instr_ready  output  1  sequencer can accept an instruction.
- alu_ctrl  output  4  to datapath ALUControl.
- rd_reg1  output  REG_AW  to datapath readReg1.
- rd_reg2  output  REG_AW  to datapath readReg2.
- wr_reg  output  REG_AW  to datapath writeReg.
- wr_data  output  DATA_W  to datapath writeData.
- wr_en  output  1  to datapath writeEnable.
- alu_result  input  DATA_W  from datapath ALUResult.
- alu_zero  input  1  from datapath Zero.
- res_data  output  DATA_W  result returned to issuer.
- res_zero  output  1  Zero flag of the result.
- res_valid  output  1  result valid.
- res_ready  input  1  issuer accepts the result.
- halted  output  1  a HALT instruction has retired.
- illegal  output  1  sticky illegal-opcode flag.

Behaviour:
- Instruction fields:
  - [31:28] op, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm.
  - op 0x0 ALU: rd ← ALU(rs1, rs2, funct = imm[3:0]).
  - op 0x1 LI: rd ← sign-extended imm.
  - op 0x2 CMP: ALU op with no writeback; result still returned.
  - op 0xF HALT.
  - Any other op is illegal.
- States: IDLE, EXEC, WB, RESP, HALT.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch instr and go to EXEC.
  - Latched fields stay stable until the next accept.
- EXEC (1 cycle):
  - rd_reg1 = rs1, rd_reg2 = rs2, alu_ctrl = funct.
  - At the edge, capture alu_result/alu_zero into internal result registers (datapath is combinational read + ALU).
  - LI: capture sign-extended imm as the result; res_zero = (imm == 0).
  - Next state: WB for ALU/LI, RESP for CMP.
  - HALT: go to HALT, no response.
  - Illegal op: set illegal, return to IDLE, no writeback, no response.
- WB (1 cycle):
  - wr_en = 1, wr_reg = rd, wr_data = captured result.
  - Next state: RESP.
- RESP:
  - res_valid = 1 with res_data/res_zero held stable.
  - On res_valid & res_ready, go to IDLE.
  - Stall indefinitely while res_ready = 0.
- HALT:
  - halted = 1, instr_ready = 0.
  - Only reset exits this state.
- Latency, accept at edge T:
  - ALU/LI: EXEC in cycle T+1, write strobe in cycle T+2, res_valid from cycle T+3.
  - CMP: res_valid from cycle T+2.
  - instr_ready returns the cycle after the response handshake; back-to-back throughput is 1 instruction per 4 cycles (ALU/LI) when res_ready is held high.
- Output defaults:
  - wr_en is 1 only in WB.
  - alu_ctrl, rd_reg1, rd_reg2, wr_reg, wr_data are 0 outside their active state.
  - instr_ready is 1 only in IDLE.
- Reset:
  - State → IDLE.
  - All outputs 0, except instr_ready = 1 after reset deasserts.
  - illegal and halted cleared; result registers cleared.
- Reset mid-operation:
  - Aborts immediately; wr_en is 0 in the cycle after the reset edge.
  - A pending response is dropped.
  - A reset asserted during WB still lets that cycle's write occur (the datapath samples on the same edge); no further writes follow.
- rd = rs1 or rd = rs2 is legal. EXEC reads the old value; WB writes the new value.
- instr_valid while not ready is ignored, and instr is not sampled.

Test Plan:
- LI r1,0x0005; LI r2,0xFFFE, with res_ready = 1:
  - First: wr_en pulse with wr_reg = 1, wr_data = 0x00000005; res_data = 5, res_zero = 0.
  - Second: wr_data = 0xFFFFFFFE (sign extension).
- After LI r1=5, r2=3: ALU rd=3, rs1=1, rs2=2, funct=ADD:
  - Cycle T+1: rd_reg1 = 1, rd_reg2 = 2, alu_ctrl = ADD.
  - Cycle T+2: wr_en = 1, wr_reg = 3, wr_data = 8.
  - res_valid from cycle T+3 with res_data = 8.
- CMP r1,r1 with funct=SUB:
  - No wr_en at any point.
  - res_valid at T+2 with res_data = 0, res_zero = 1.
- Backpressure: hold res_ready = 0 for 10 cycles after an ALU op:
  - res_valid stays 1 with stable data; instr_ready stays 0; instr_valid is ignored.
  - Release res_ready: handshake completes, and instr_ready = 1 next cycle.
- Illegal op 0x7 → illegal = 1, no wr_en, no res_valid, back in IDLE at T+2. Then HALT → halted = 1, instr_ready = 0 permanently.
- Reset asserted during EXEC of an ALU op:
  - No wr_en follows; all outputs return to defaults.
  - illegal and halted are cleared.
  - A subsequent LI executes normally.
